// File: rtl/rijndael_encrypt_arbiter.sv
// Round-robin front end that shares one iterative Rijndael encryption core
// between NREQ valid/ready requesters and returns ID-tagged ciphertexts.

module rijndael_encrypt #(
  parameter int NB = 4,
  parameter int NK = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic [32*NB-1:0] plaintext_i,
  input  logic [32*NK-1:0] key_i,
  output logic [32*NB-1:0] ciphertext_o,
  output logic             ready_o
);
  localparam int SS  = 32*NB;
  localparam int KS  = 32*NK;
  localparam int NR  = ((NB > NK) ? NB : NK) + 6;
  localparam int RW  = $clog2(NR+1);
  localparam int KJW = $clog2(NK+1);
  localparam int KPW = (NK > 1) ? $clog2(NK) : 1;
  localparam logic [RW-1:0] NR_L = RW'(NR);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic int shoff(input int r);
    if (r == 1) return 1;
    if (r == 2) return (NB == 8) ? 3 : 2;
    if (r == 3) return (NB >= 7) ? 4 : 3;
    return 0;
  endfunction

  logic           r_act;
  logic           r_init;
  logic [RW-1:0]  r_round;
  logic [KJW-1:0] r_kj;
  logic [KPW-1:0] r_kpos;
  logic [7:0]     r_rc;
  logic [31:0]    r_kwin [NK];
  logic [SS-1:0]  r_state;

  int             w_j;
  int             w_pos;
  logic [7:0]     w_rc;
  logic [31:0]    w_t;
  logic [31:0]    w_tmp;
  logic [31:0]    w_win [NK];
  logic [31:0]    w_rk [NB];
  logic [SS-1:0]  w_rkp;
  logic [7:0]     w_sb [4][NB];
  logic [7:0]     w_a [4];
  logic [31:0]    w_col;
  logic [SS-1:0]  w_round;
  logic           w_last;

  // On-the-fly key expansion: NB words per cycle from a sliding window of the
  // last NK words; the first NK words come straight from key_i.
  always_comb begin
    w_j   = int'(r_kj);
    w_pos = int'(r_kpos);
    w_rc  = r_rc;
    w_t   = '0;
    w_tmp = '0;
    w_rkp = '0;
    for (int k = 0; k < NK; k++) w_win[k] = r_kwin[k];
    for (int c = 0; c < NB; c++) begin
      w_tmp = '0;
      if (w_j < NK) begin
        for (int k = 0; k < NK; k++)
          if (k == w_j) w_tmp = key_i[KS-1-32*k -: 32];
      end else begin
        w_t = w_win[NK-1];
        if (w_pos == 0) begin
          w_t  = subword({w_t[23:0], w_t[31:24]}) ^ {w_rc, 24'h000000};
          w_rc = xt(w_rc);
        end else if (NK > 6 && w_pos == 4) begin
          w_t = subword(w_t);
        end
        w_tmp = w_win[0] ^ w_t;
      end
      w_rk[c] = w_tmp;
      w_rkp[SS-1-32*c -: 32] = w_tmp;
      for (int k = 0; k < NK-1; k++) w_win[k] = w_win[k+1];
      w_win[NK-1] = w_tmp;
      w_pos = (w_pos == NK-1) ? 0 : w_pos + 1;
      if (w_j < NK) w_j = w_j + 1;
    end
  end

  assign w_last = (r_round == NR_L);

  always_comb begin
    w_round = '0;
    w_col   = '0;
    for (int c = 0; c < NB; c++)
      for (int r = 0; r < 4; r++)
        w_sb[r][c] = sbox(r_state[SS-1-32*c-8*r -: 8]);
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) w_a[r] = w_sb[r][(c + shoff(r)) % NB];
      if (w_last)
        w_col = {w_a[0], w_a[1], w_a[2], w_a[3]};
      else
        w_col = {xt(w_a[0]) ^ xt(w_a[1]) ^ w_a[1] ^ w_a[2] ^ w_a[3],
                 w_a[0] ^ xt(w_a[1]) ^ xt(w_a[2]) ^ w_a[2] ^ w_a[3],
                 w_a[0] ^ w_a[1] ^ xt(w_a[2]) ^ xt(w_a[3]) ^ w_a[3],
                 xt(w_a[0]) ^ w_a[0] ^ w_a[1] ^ w_a[2] ^ xt(w_a[3])};
      w_round[SS-1-32*c -: 32] = w_col ^ w_rk[c];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_act   <= 1'b0;
      r_init  <= 1'b0;
      r_round <= '0;
      r_kj    <= '0;
      r_kpos  <= '0;
      r_rc    <= 8'h01;
    end else if (!r_act) begin
      if (enable_i) begin
        r_act  <= 1'b1;
        r_init <= 1'b1;
        r_kj   <= '0;
        r_kpos <= '0;
        r_rc   <= 8'h01;
      end
    end else begin
      r_init  <= 1'b0;
      r_state <= r_init ? (plaintext_i ^ w_rkp) : w_round;
      r_kj    <= KJW'(w_j);
      r_kpos  <= KPW'(w_pos);
      r_rc    <= w_rc;
      r_kwin  <= w_win;
      if (r_init)              r_round <= RW'(1);
      else if (r_round == NR_L) r_act  <= 1'b0;
      else                     r_round <= r_round + RW'(1);
    end
  end

  assign ready_o      = ~r_act;
  assign ciphertext_o = r_state;
endmodule

module rijndael_encrypt_arbiter #(
  parameter int NB   = 4,
  parameter int NK   = 4,
  parameter int NREQ = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NREQ-1:0]                      req_valid_i,
  output logic [NREQ-1:0]                      req_ready_o,
  input  logic [NREQ*32*NB-1:0]                req_plaintext_i,
  input  logic [NREQ*32*NK-1:0]                req_key_i,
  output logic                                 rsp_valid_o,
  input  logic                                 rsp_ready_i,
  output logic [((NREQ>1)?$clog2(NREQ):1)-1:0] rsp_id_o,
  output logic [32*NB-1:0]                     rsp_ciphertext_o,
  output logic                                 busy_o
);
  localparam int STATESIZE = 32*NB;
  localparam int KEYSIZE   = 32*NK;
  localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_RESP} state_t;

  state_t               r_fsm;
  logic [IDW-1:0]       r_rr;
  logic [IDW-1:0]       r_id;
  logic [STATESIZE-1:0] r_pt;
  logic [KEYSIZE-1:0]   r_key;
  logic [STATESIZE-1:0] r_rsp_ct;

  logic [2*NREQ-1:0]    w_dbl;
  logic                 w_any;
  int                   w_off;
  int                   w_gi;
  int                   w_ni;
  logic [STATESIZE-1:0] w_pt;
  logic [KEYSIZE-1:0]   w_key;
  logic                 w_core_ready;
  logic [STATESIZE-1:0] w_core_ct;

  // Rotate the valid vector so bit 0 is the pointer position, then take the
  // lowest set bit.
  always_comb begin
    w_dbl = {req_valid_i, req_valid_i} >> r_rr;
    w_any = 1'b0;
    w_off = 0;
    for (int k = NREQ-1; k >= 0; k--)
      if (w_dbl[k]) begin
        w_any = 1'b1;
        w_off = k;
      end
    w_gi = int'(r_rr) + w_off;
    if (w_gi >= NREQ) w_gi = w_gi - NREQ;
    w_ni = w_gi + 1;
    if (w_ni >= NREQ) w_ni = 0;
    w_pt        = '0;
    w_key       = '0;
    req_ready_o = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_gi == i) begin
        w_pt           = req_plaintext_i[i*STATESIZE +: STATESIZE];
        w_key          = req_key_i[i*KEYSIZE +: KEYSIZE];
        req_ready_o[i] = (r_fsm == S_IDLE) && w_any && !rst_i;
      end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fsm    <= S_IDLE;
      r_rr     <= '0;
      r_id     <= '0;
      r_pt     <= '0;
      r_key    <= '0;
      r_rsp_ct <= '0;
    end else begin
      case (r_fsm)
        S_IDLE:
          if (w_any) begin
            r_pt  <= w_pt;
            r_key <= w_key;
            r_id  <= IDW'(w_gi);
            r_rr  <= IDW'(w_ni);
            r_fsm <= S_START;
          end
        S_START: r_fsm <= S_RUN;
        S_RUN:
          if (w_core_ready) begin
            r_rsp_ct <= w_core_ct;
            r_fsm    <= S_RESP;
          end
        S_RESP:
          if (rsp_ready_i) r_fsm <= S_IDLE;
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  rijndael_encrypt #(.NB(NB), .NK(NK)) u_core (
    .clk_i        (clk_i),
    .rst_ni       (~rst_i),
    .enable_i     (r_fsm == S_START),
    .plaintext_i  (r_pt),
    .key_i        (r_key),
    .ciphertext_o (w_core_ct),
    .ready_o      (w_core_ready)
  );

  assign rsp_valid_o      = (r_fsm == S_RESP) && !rst_i;
  assign rsp_id_o         = rst_i ? '0 : r_id;
  assign rsp_ciphertext_o = rst_i ? '0 : r_rsp_ct;
  assign busy_o           = (r_fsm != S_IDLE) && !rst_i;
endmodule

// File: tb/tb_rijndael_encrypt_arbiter.sv
// Directed scoreboard bench for rijndael_encrypt_arbiter with four AES-128 requesters.

module tb_rijndael_encrypt_arbiter;
  localparam int NREQ = 4;
  localparam int SS   = 128;
  localparam int KS   = 128;
  localparam int IDW  = 2;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [NREQ*SS-1:0]   req_plaintext_i;
  logic [NREQ*KS-1:0]   req_key_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [IDW-1:0]       rsp_id_o;
  logic [SS-1:0]        rsp_ciphertext_o;
  logic                 busy_o;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [SS-1:0]  ct;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  rijndael_encrypt_arbiter #(.NB(4), .NK(4), .NREQ(NREQ)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_plaintext_i  (req_plaintext_i),
    .req_key_i        (req_key_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_id_o         (rsp_id_o),
    .rsp_ciphertext_o (rsp_ciphertext_o),
    .busy_o           (busy_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; every cycle the grant must be one-hot-or-zero and only for valid requesters
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("ready_subset_of_valid", 128'(req_ready_o & ~req_valid_i), 128'd0);
    chk("ready_onehot0", 128'($onehot0(req_ready_o)), 128'd1);
  endtask

  task automatic set_req(input int i, input logic v, input logic [127:0] pt, input logic [127:0] key);
    req_valid_i[i]             = v;
    req_plaintext_i[i*SS +: SS] = pt;
    req_key_i[i*KS +: KS]       = key;
  endtask

  function automatic exp_t mk(input int id, input logic [127:0] ct);
    exp_t e;
    e.id = IDW'(id);
    e.ct = ct;
    return e;
  endfunction

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid_o !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("rsp_valid_timeout", 128'(rsp_valid_o), 128'd1);
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 128'(sb.size() != 0), 128'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_id"}, 128'(rsp_id_o), 128'(e.id));
      chk({tag, "_ct"}, rsp_ciphertext_o, e.ct);
    end
  endtask

  initial begin
    int n;
    int last;
    rst             = 1'b1;
    rsp_ready_i     = 1'b1;
    req_valid_i     = '0;
    req_plaintext_i = '0;
    req_key_i       = '0;
    tick();
    tick();

    // Reset state, with a request pending that must not be granted
    set_req(0, 1'b1, PT_B, KEY_B);
    #1;
    chk("rst_ready", 128'(req_ready_o), 128'd0);
    chk("rst_busy", 128'(busy_o), 128'd0);
    chk("rst_rsp_valid", 128'(rsp_valid_o), 128'd0);
    chk("rst_rsp_id", 128'(rsp_id_o), 128'd0);
    chk("rst_rsp_ct", rsp_ciphertext_o, 128'd0);
    req_valid_i[0] = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_rsp_valid", 128'(rsp_valid_o), 128'd0);
    chk("post_rst_busy", 128'(busy_o), 128'd0);
    chk("post_rst_rsp_ct", rsp_ciphertext_o, 128'd0);

    // Single request, FIPS-197 App. B, latency 14
    set_req(0, 1'b1, PT_B, KEY_B);
    #1;
    chk("t1_grant", 128'(req_ready_o), 128'b0001);
    sb.push_back(mk(0, CT_B));
    tick();
    req_valid_i[0] = 1'b0;
    chk("t1_busy", 128'(busy_o), 128'd1);
    wait_rsp(n);
    chk("t1_latency", 128'(n + 1), 128'd14);
    check_rsp("t1");
    tick();

    // Data isolation on requester 3: inputs change right after acceptance
    set_req(3, 1'b1, PT_B, KEY_B);
    #1;
    chk("iso_grant", 128'(req_ready_o), 128'b1000);
    sb.push_back(mk(3, CT_B));
    tick();
    set_req(3, 1'b0, PT_C, KEY_C);
    wait_rsp(n);
    check_rsp("iso");
    tick();

    // Mid-operation reset during core round 5
    set_req(0, 1'b1, PT_C, KEY_C);
    #1;
    chk("mr_grant", 128'(req_ready_o), 128'b0001);
    tick();
    req_valid_i[0] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("mr_busy_before", 128'(busy_o), 128'd1);
    rst = 1'b1;
    #1;
    chk("mr_busy_in_rst", 128'(busy_o), 128'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("mr_busy_after", 128'(busy_o), 128'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("mr_no_rsp", 128'(rsp_valid_o), 128'd0);
    end
    set_req(0, 1'b1, PT_B, KEY_B);
    set_req(1, 1'b1, PT_C, KEY_C);
    #1;
    chk("mr_ptr_reset_grant", 128'(req_ready_o), 128'b0001);
    sb.push_back(mk(0, CT_B));
    tick();
    req_valid_i[0] = 1'b0;
    sb.push_back(mk(1, CT_C));
    wait_rsp(n);
    chk("mr_latency", 128'(n + 1), 128'd14);
    check_rsp("mr0");
    tick();
    chk("mr_next_grant", 128'(req_ready_o), 128'b0010);
    tick();
    req_valid_i[1] = 1'b0;
    wait_rsp(n);
    check_rsp("mr1");
    tick();

    // Round-robin fairness, all requesters continuously valid
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, PT_C, KEY_C);
    #1;
    chk("rr_first_grant", 128'(req_ready_o), 128'b0001);
    sb.push_back(mk(0, CT_C));
    sb.push_back(mk(1, CT_C));
    sb.push_back(mk(2, CT_C));
    sb.push_back(mk(3, CT_C));
    sb.push_back(mk(0, CT_C));
    last = 0;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(n);
      if (k > 0) chk("rr_spacing", 128'(cyc - last), 128'd15);
      last = cyc;
      check_rsp("rr");
      if (k == 4) req_valid_i = '0;
      tick();
    end
    chk("rr_sb_drained", 128'(sb.size()), 128'd0);

    // Response backpressure for 20 cycles with another request pending
    set_req(2, 1'b1, PT_B, KEY_B);
    #1;
    chk("bp_grant", 128'(req_ready_o), 128'b0100);
    sb.push_back(mk(2, CT_B));
    rsp_ready_i = 1'b0;
    tick();
    req_valid_i[2] = 1'b0;
    set_req(1, 1'b1, PT_C, KEY_C);
    wait_rsp(n);
    check_rsp("bp");
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_valid_held", 128'(rsp_valid_o), 128'd1);
      chk("bp_id_held", 128'(rsp_id_o), 128'd2);
      chk("bp_ct_held", rsp_ciphertext_o, CT_B);
      chk("bp_no_ready", 128'(req_ready_o), 128'd0);
    end
    rsp_ready_i = 1'b1;
    sb.push_back(mk(1, CT_C));
    tick();
    chk("bp_next_grant", 128'(req_ready_o), 128'b0010);
    tick();
    req_valid_i[1] = 1'b0;
    wait_rsp(n);
    check_rsp("bp_next");
    tick();

    // Pointer skip with only requesters 1 and 3 valid
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(1, 1'b1, PT_B, KEY_B);
    set_req(3, 1'b1, PT_C, KEY_C);
    #1;
    chk("skip_first_grant", 128'(req_ready_o), 128'b0010);
    sb.push_back(mk(1, CT_B));
    sb.push_back(mk(3, CT_C));
    sb.push_back(mk(1, CT_B));
    for (int k = 0; k < 3; k++) begin
      wait_rsp(n);
      check_rsp("skip");
      if (k == 2) req_valid_i = '0;
      tick();
    end
    chk("final_sb_drained", 128'(sb.size()), 128'd0);
    chk("final_idle", 128'(busy_o), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
